relax_sequencer: RTL and testbench

// Sequences relaxation of the switch-level node/transistor network: issues step

---
 rtl/relax_sequencer.sv | 152 +++++++++++++++
 tb/tb_relax_sequencer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/relax_sequencer.sv
// relax_sequencer
//
// Drives relaxation of the switch-level node network. Each simulated clock
// half-cycle is a sequence of STEP/CHECK pairs: STEP lets the node integrators
// apply v += i for one clock. CHECK then waits one clock so that imax reflects
// the updated voltages. Once the network has settled, or the step limit is hit,
// phi0 toggles into the clock pad. The host asks for a number of half-cycles
// with a start/done handshake and can abort at any time.
//
// Ports
//   clk             in   system clock
//   reset           in   synchronous, active-high
//   start           in   run request, only honoured in IDLE
//   abort           in   terminate run, back to IDLE on the next clock
//   cycles          in   [CW-1:0] half-cycles to run, latched on accepted start
//   imax            in   [W-1:0]  unsigned peak |i| over all nodes
//   settle_thr      in   [W-1:0]  unsigned convergence threshold
//   step_en         out  integrators apply v += i this cycle
//   phi0            out  simulated chip clock level
//   busy            out  run in progress
//   done            out  one-cycle pulse at run completion
//   timeout         out  sticky, a half-cycle of this run hit MAX_STEPS
//   steps_last      out  [7:0]    steps used by the latest half-cycle (saturating)
//   halfcycle_count out  [CW-1:0] half-cycles completed since reset (wraps)

module relax_sequencer #(
    parameter int W         = 16,
    parameter int MIN_STEPS = 4,
    parameter int MAX_STEPS = 64,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [CW-1:0] cycles,
    input  logic [W-1:0]  imax,
    input  logic [W-1:0]  settle_thr,
    output logic          step_en,
    output logic          phi0,
    output logic          busy,
    output logic          done,
    output logic          timeout,
    output logic [7:0]    steps_last,
    output logic [CW-1:0] halfcycle_count
);

    // Step counter only ever counts up to MAX_STEPS.
    localparam int SCW = $clog2(MAX_STEPS + 1);
    localparam logic [SCW-1:0] MIN_C = SCW'(MIN_STEPS);
    localparam logic [SCW-1:0] MAX_C = SCW'(MAX_STEPS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STEP,
        S_CHECK,
        S_TOGGLE,
        S_DONE
    } state_t;

    state_t          state;
    logic [CW-1:0]   remain;
    logic [SCW-1:0]  step_cnt;
    logic [7:0]      step_sat;

    // steps_last is 8 bits wide but MAX_STEPS may be larger, so clamp at 255.
    // NOTE: every variable assigned in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        step_sat = 8'hFF;
        if (32'(step_cnt) <= 32'd255)
            step_sat = 8'(step_cnt);
    end

    // NOTE: all state and outputs update with non-blocking assignments so every
    // branch sees the values from before this edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            remain          <= '0;
            step_cnt        <= '0;
            step_en         <= 1'b0;
            phi0            <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            timeout         <= 1'b0;
            steps_last      <= '0;
            halfcycle_count <= '0;
        end else if (abort && state != S_IDLE) begin
            // Abort beats every other transition; phi0, counters and timeout hold.
            state   <= S_IDLE;
            busy    <= 1'b0;
            step_en <= 1'b0;
            done    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (cycles != '0) begin
                            remain   <= cycles;
                            step_cnt <= '0;
                            timeout  <= 1'b0;
                            busy     <= 1'b1;
                            step_en  <= 1'b1;
                            state    <= S_STEP;
                        end else begin
                            // Empty request: complete immediately, phi0 untouched.
                            done  <= 1'b1;
                            state <= S_DONE;
                        end
                    end
                end
                S_STEP: begin
                    step_en  <= 1'b0;
                    step_cnt <= step_cnt + 1'b1;
                    state    <= S_CHECK;
                end
                S_CHECK: begin
                    if (step_cnt >= MIN_C && imax <= settle_thr) begin
                        state <= S_TOGGLE;
                    end else if (step_cnt == MAX_C) begin
                        timeout <= 1'b1;
                        state   <= S_TOGGLE;
                    end else begin
                        step_en <= 1'b1;
                        state   <= S_STEP;
                    end
                end
                S_TOGGLE: begin
                    phi0            <= ~phi0;
                    remain          <= remain - 1'b1;
                    halfcycle_count <= halfcycle_count + 1'b1;
                    steps_last      <= step_sat;
                    step_cnt        <= '0;
                    if (remain == CW'(1)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_DONE;
                    end else begin
                        step_en <= 1'b1;
                        state   <= S_STEP;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_relax_sequencer.sv
// tb_relax_sequencer
//
// Directed bench for relax_sequencer. Each run pushes its expected completion
// record (cycle of done, phi0, steps_last, halfcycle_count, timeout, step
// pulses) into a scoreboard queue; the record is popped and compared when the
// done pulse appears. Abort and reset behaviour is checked inline.

module tb_relax_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        abort;
    logic [15:0] cycles;
    logic [15:0] imax;
    logic [15:0] settle_thr;
    logic        step_en;
    logic        phi0;
    logic        busy;
    logic        done;
    logic        timeout;
    logic [7:0]  steps_last;
    logic [15:0] halfcycle_count;

    relax_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .cycles          (cycles),
        .imax            (imax),
        .settle_thr      (settle_thr),
        .step_en         (step_en),
        .phi0            (phi0),
        .busy            (busy),
        .done            (done),
        .timeout         (timeout),
        .steps_last      (steps_last),
        .halfcycle_count (halfcycle_count)
    );

    always #5 clk = ~clk;

    // Node-network stand-in: either a fixed current, or 100 until the
    // 10th integration step of the run and 5 afterwards.
    logic        imax_mode;
    logic [15:0] imax_val;
    int          step_seen;
    int          cyc;
    int          done_cnt;

    assign imax = imax_mode ? ((step_seen >= 10) ? 16'd5 : 16'd100) : imax_val;

    // Cycle/step monitor, restarted by an accepted start.
    always @(posedge clk) begin
        if (reset) begin
            cyc       <= 0;
            step_seen <= 0;
            done_cnt  <= 0;
        end else begin
            if (start && !busy) begin
                cyc       <= 1;
                step_seen <= 0;
            end else begin
                cyc <= cyc + 1;
                if (step_en) step_seen <= step_seen + 1;
            end
            if (done) done_cnt <= done_cnt + 1;
        end
    end

    typedef struct {
        int          cyc;
        logic        phi0;
        logic [7:0]  sl;
        logic [15:0] hc;
        logic        to;
        int          steps;
    } exp_t;

    exp_t sb[$];

    int n_assert = 0;
    int n_fail   = 0;

    logic        exp_phi;
    logic [15:0] exp_hc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive a start; the accepting edge is consumed here.
    task automatic start_run(input logic [15:0] n);
        cycles = n;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // Push the expected completion record of a run with n half-cycles of s steps.
    task automatic push_exp(input int n, input int s, input logic to);
        exp_t e;
        e.cyc   = n * (2 * s + 1) + 1;
        exp_phi = exp_phi ^ n[0];
        exp_hc  = exp_hc + 16'(n);
        e.phi0  = exp_phi;
        e.sl    = 8'(s);
        e.hc    = exp_hc;
        e.to    = to;
        e.steps = n * s;
        sb.push_back(e);
    endtask

    // Wait (bounded) for done, then pop and compare the scoreboard entry.
    task automatic wait_and_score(input string name, input int budget);
        exp_t e;
        bit   ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check({name, "_done_seen"}, 32'(ok), 32'd1);
        e = sb.pop_front();
        check({name, "_done_cycle"}, cyc, e.cyc);
        check({name, "_phi0"}, 32'(phi0), 32'(e.phi0));
        check({name, "_steps_last"}, 32'(steps_last), 32'(e.sl));
        check({name, "_halfcycles"}, 32'(halfcycle_count), 32'(e.hc));
        check({name, "_timeout"}, 32'(timeout), 32'(e.to));
        check({name, "_step_pulses"}, step_seen, e.steps);
        check({name, "_busy_at_done"}, 32'(busy), 32'd0);
        tick();
        check({name, "_done_one_cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        int base_done;
        bit ok;

        exp_phi    = 1'b0;
        exp_hc     = '0;
        imax_mode  = 1'b0;
        imax_val   = 16'd0;
        settle_thr = 16'd0;
        abort      = 1'b0;
        cycles     = 16'd3;

        // 1: reset held with start asserted.
        reset = 1'b1;
        start = 1'b1;
        tick();
        tick();
        check("rst_step_en", 32'(step_en), 32'd0);
        check("rst_phi0", 32'(phi0), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_steps_last", 32'(steps_last), 32'd0);
        check("rst_halfcycles", 32'(halfcycle_count), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        tick();
        check("post_rst_idle_busy", 32'(busy), 32'd0);

        // 2: two settled half-cycles, 4 steps each, done in clock 19.
        imax_val   = 16'd0;
        settle_thr = 16'd0;
        push_exp(2, 4, 1'b0);
        start_run(16'd2);
        check("t2_busy_after_start", 32'(busy), 32'd1);
        check("t2_step_en_first", 32'(step_en), 32'd1);
        tick();
        check("t2_step_en_check_low", 32'(step_en), 32'd0);
        wait_and_score("t2", 100);

        // 3: never settles, hits the step limit.
        imax_val   = 16'd100;
        settle_thr = 16'd10;
        push_exp(1, 64, 1'b1);
        start_run(16'd1);
        wait_and_score("t3", 300);

        // 5: abort in the 3rd of 5 half-cycles (phi0 starts at 1).
        base_done = done_cnt;
        start_run(16'd5);
        check("t5_timeout_cleared", 32'(timeout), 32'd0);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (halfcycle_count == exp_hc + 16'd2) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("t5_two_halfcycles_seen", 32'(ok), 32'd1);
        repeat (5) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        exp_hc = exp_hc + 16'd2;
        check("t5_abort_busy", 32'(busy), 32'd0);
        check("t5_abort_step_en", 32'(step_en), 32'd0);
        check("t5_abort_done", 32'(done), 32'd0);
        check("t5_abort_phi0", 32'(phi0), 32'(exp_phi));
        check("t5_abort_halfcycles", 32'(halfcycle_count), 32'(exp_hc));
        check("t5_abort_steps_last", 32'(steps_last), 32'd64);
        check("t5_abort_timeout", 32'(timeout), 32'd1);
        repeat (4) tick();
        check("t5_no_done_pulse", done_cnt, base_done);
        check("t5_idle_step_en", 32'(step_en), 32'd0);

        // 4: settles after 10 steps; new start clears timeout.
        imax_mode = 1'b1;
        push_exp(1, 10, 1'b0);
        start_run(16'd1);
        check("t4_timeout_cleared", 32'(timeout), 32'd0);
        wait_and_score("t4", 100);
        imax_mode = 1'b0;

        // 6a: zero-cycle request completes at once, phi0 untouched.
        imax_val   = 16'd0;
        settle_thr = 16'd0;
        start_run(16'd0);
        check("t6_zero_done", 32'(done), 32'd1);
        check("t6_zero_busy", 32'(busy), 32'd0);
        check("t6_zero_step_en", 32'(step_en), 32'd0);
        check("t6_zero_phi0", 32'(phi0), 32'(exp_phi));
        tick();
        check("t6_zero_done_pulse", 32'(done), 32'd0);
        check("t6_zero_halfcycles", 32'(halfcycle_count), 32'(exp_hc));

        // 6b: start pulses while busy must not disturb the run.
        push_exp(2, 4, 1'b0);
        start_run(16'd2);
        repeat (3) tick();
        cycles = 16'd7;
        start  = 1'b1;
        tick();
        start  = 1'b0;
        repeat (6) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_and_score("t6b", 100);

        // Reset mid-run after the first toggle: phi0 and counters back to 0.
        start_run(16'd3);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (phi0 != exp_phi) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        check("rst_mid_toggle_seen", 32'(ok), 32'd1);
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_phi0", 32'(phi0), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_step_en", 32'(step_en), 32'd0);
        check("rst_mid_halfcycles", 32'(halfcycle_count), 32'd0);
        check("rst_mid_steps_last", 32'(steps_last), 32'd0);
        tick();
        check("rst_mid_stays_idle", 32'(step_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
